// File: rtl/risc_toy_pkg.sv
// Shared definitions for the risc_toy pipeline: fetch FSM encoding, reset PC
// default, ISA opcode constants and the link-address helper.
package risc_toy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [29:0] RESET_PC_DEFAULT = 30'h0000_0000;

    // Primary opcode field INSTR[31:26], consumed by decode/execute.
    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_AND  = 6'h02;
    localparam logic [5:0] OP_OR   = 6'h03;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LD   = 6'h10;
    localparam logic [5:0] OP_ST   = 6'h11;
    localparam logic [5:0] OP_BR   = 6'h20;
    localparam logic [5:0] OP_BRL  = 6'h21;
    localparam logic [5:0] OP_J    = 6'h22;
    localparam logic [5:0] OP_JL   = 6'h23;

    // Byte address of the instruction after pc; wraps modulo 2^32.
    function automatic logic [31:0] link_addr(input logic [29:0] pc);
        return {pc + 30'd1, 2'b00};
    endfunction

endpackage

// File: rtl/risc_toy_fetch.sv
// Instruction fetch stage: PC register, IDLE/RUN/HOLD fetch FSM and the
// fetch/decode pipeline register with stall hold and redirect flush.
module risc_toy_fetch
    import risc_toy_pkg::*;
#(
    parameter logic [29:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        CLK,
    input  logic        RSTN,
    output logic        IREQ,
    output logic [29:0] IADDR,
    input  logic [31:0] INSTR,
    input  logic        STALL,
    input  logic        REDIRECT,
    input  logic [29:0] REDIRECT_PC,
    output logic        FD_VALID,
    output logic [31:0] FD_INSTR,
    output logic [29:0] FD_PC,
    output logic [31:0] FD_LINK
);

    fetch_state_e state_r, state_s;
    logic [29:0]  pc_r, pc_s;
    logic         ireq_r;
    logic         fd_valid_r, fd_valid_s;
    logic [31:0]  fd_instr_r, fd_instr_s;
    logic [29:0]  fd_pc_r, fd_pc_s;

    // Next-state and next-datapath logic; a redirect overrides any stall.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        fd_valid_s = fd_valid_r;
        fd_instr_s = fd_instr_r;
        fd_pc_s    = fd_pc_r;
        if (REDIRECT) begin
            pc_s       = REDIRECT_PC;
            fd_valid_s = 1'b0;
            fd_instr_s = 32'h0000_0000;
            state_s    = ST_RUN;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_RUN;
                end
                ST_RUN: begin
                    if (STALL) begin
                        state_s = ST_HOLD;
                    end else begin
                        pc_s       = pc_r + 30'd1;
                        fd_instr_s = INSTR;
                        fd_pc_s    = pc_r;
                        fd_valid_s = 1'b1;
                    end
                end
                ST_HOLD: begin
                    // PC is left alone so the held address is fetched again.
                    if (STALL) begin
                        state_s = ST_HOLD;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, PC, request and fetch/decode register update.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_PC;
            ireq_r     <= 1'b0;
            fd_valid_r <= 1'b0;
            fd_instr_r <= 32'h0000_0000;
            fd_pc_r    <= 30'h0000_0000;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            ireq_r     <= (state_s == ST_RUN);
            fd_valid_r <= fd_valid_s;
            fd_instr_r <= fd_instr_s;
            fd_pc_r    <= fd_pc_s;
        end
    end

    assign IREQ     = ireq_r;
    assign IADDR    = pc_r;
    assign FD_VALID = fd_valid_r;
    assign FD_INSTR = fd_instr_r;
    assign FD_PC    = fd_pc_r;
    assign FD_LINK  = link_addr(fd_pc_r);

endmodule

// File: tb/tb_risc_toy_fetch.sv
// Self-checking bench for risc_toy_fetch: an abstract fetch model compared on
// every falling edge, plus directed scenarios with literal expectations.
module tb_risc_toy_fetch;

    localparam logic [29:0] RST_PC = 30'h0000_0000;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        IREQ;
    logic [29:0] IADDR;
    logic [31:0] INSTR;
    logic        STALL;
    logic        REDIRECT;
    logic [29:0] REDIRECT_PC;
    logic        FD_VALID;
    logic [31:0] FD_INSTR;
    logic [29:0] FD_PC;
    logic [31:0] FD_LINK;

    int n_tests = 0;
    int n_fail  = 0;

    risc_toy_fetch #(.RESET_PC(RST_PC)) dut (
        .CLK(CLK), .RSTN(RSTN), .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
        .STALL(STALL), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .FD_VALID(FD_VALID), .FD_INSTR(FD_INSTR), .FD_PC(FD_PC), .FD_LINK(FD_LINK)
    );

    always #5 CLK = ~CLK;

    // Instruction memory: the word at address a is {a, 2'b11}.
    function automatic logic [31:0] instr_of(input logic [29:0] a);
        return {a, 2'b11};
    endfunction

    assign INSTR = instr_of(IADDR);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Abstract model: warm-up cycle after reset, waiting flag after a stall,
    // otherwise fetch one word per cycle.
    logic        m_warm, m_held, m_valid;
    logic [29:0] m_pc, m_fd_pc;
    logic [31:0] m_fd_instr;

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            m_warm     <= 1'b1;
            m_held     <= 1'b0;
            m_valid    <= 1'b0;
            m_pc       <= RST_PC;
            m_fd_pc    <= 30'h0;
            m_fd_instr <= 32'h0;
        end else if (REDIRECT) begin
            m_pc       <= REDIRECT_PC;
            m_valid    <= 1'b0;
            m_fd_instr <= 32'h0;
            m_warm     <= 1'b0;
            m_held     <= 1'b0;
        end else if (m_warm) begin
            m_warm <= 1'b0;
        end else if (m_held) begin
            m_held <= STALL;
        end else if (STALL) begin
            m_held <= 1'b1;
        end else begin
            m_fd_instr <= instr_of(m_pc);
            m_fd_pc    <= m_pc;
            m_valid    <= 1'b1;
            m_pc       <= m_pc + 30'd1;
        end
    end

    // Compare DUT against the model every cycle.
    always @(negedge CLK) begin
        chk("m_ireq",     {31'd0, IREQ},     {31'd0, !m_warm && !m_held});
        chk("m_iaddr",    {2'b00, IADDR},    {2'b00, m_pc});
        chk("m_fd_valid", {31'd0, FD_VALID}, {31'd0, m_valid});
        chk("m_fd_instr", FD_INSTR,          m_fd_instr);
        if (m_valid) begin
            chk("m_fd_pc",   {2'b00, FD_PC}, {2'b00, m_fd_pc});
            chk("m_fd_link", FD_LINK,        ({2'b00, m_fd_pc} + 32'd1) * 32'd4);
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    initial begin
        RSTN = 1'b0;
        STALL = 1'b0;
        REDIRECT = 1'b0;
        REDIRECT_PC = 30'h0;
        tick();
        tick();
        chk("rst_ireq",  {31'd0, IREQ},     32'd0);
        chk("rst_valid", {31'd0, FD_VALID}, 32'd0);
        chk("rst_iaddr", {2'b00, IADDR},    32'd0);
        chk("rst_instr", FD_INSTR,          32'd0);
        #2 RSTN = 1'b1;

        // Straight-line fetch after release: one IDLE cycle then 0,1,2,3.
        tick();
        chk("seq_ireq0",  {31'd0, IREQ},     32'd1);
        chk("seq_iaddr0", {2'b00, IADDR},    32'd0);
        chk("seq_valid0", {31'd0, FD_VALID}, 32'd0);
        tick();
        chk("seq_iaddr1", {2'b00, IADDR},    32'd1);
        chk("seq_fdpc0",  {2'b00, FD_PC},    32'd0);
        chk("seq_fdins0", FD_INSTR,          32'h0000_0003);
        chk("seq_valid1", {31'd0, FD_VALID}, 32'd1);
        chk("seq_link0",  FD_LINK,           32'h0000_0004);
        tick();
        chk("seq_fdpc1",  {2'b00, FD_PC},    32'd1);
        tick();
        chk("seq_iaddr3", {2'b00, IADDR},    32'd3);
        chk("seq_fdpc2",  {2'b00, FD_PC},    32'd2);
        tick();
        tick();

        // Stall while PC=5.
        chk("stl_iaddr5", {2'b00, IADDR}, 32'd5);
        STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stl_ireq",  {31'd0, IREQ},  32'd0);
            chk("stl_iaddr", {2'b00, IADDR}, 32'd5);
            chk("stl_fdpc",  {2'b00, FD_PC}, 32'd4);
            chk("stl_fdins", FD_INSTR,       32'h0000_0013);
        end
        STALL = 1'b0;
        tick();
        chk("stl_rel_ireq", {31'd0, IREQ},  32'd1);
        chk("stl_rel_addr", {2'b00, IADDR}, 32'd5);
        tick();
        chk("stl_fdpc5",    {2'b00, FD_PC}, 32'd5);
        chk("stl_fdins5",   FD_INSTR,       32'h0000_0017);
        tick();
        tick();
        tick();

        // Redirect to 0x40 while PC=9.
        chk("rd_iaddr9", {2'b00, IADDR}, 32'd9);
        REDIRECT = 1'b1;
        REDIRECT_PC = 30'h40;
        tick();
        REDIRECT = 1'b0;
        chk("rd_iaddr",  {2'b00, IADDR},    32'h40);
        chk("rd_valid",  {31'd0, FD_VALID}, 32'd0);
        chk("rd_instr",  FD_INSTR,          32'd0);
        tick();
        chk("rd_fdpc",   {2'b00, FD_PC},    32'h40);
        chk("rd_valid1", {31'd0, FD_VALID}, 32'd1);

        // Simultaneous redirect and stall to 0x10.
        REDIRECT = 1'b1;
        STALL = 1'b1;
        REDIRECT_PC = 30'h10;
        tick();
        REDIRECT = 1'b0;
        STALL = 1'b0;
        chk("rs_iaddr", {2'b00, IADDR},    32'h10);
        chk("rs_ireq",  {31'd0, IREQ},     32'd1);
        chk("rs_valid", {31'd0, FD_VALID}, 32'd0);
        tick();
        chk("rs_fdpc",  {2'b00, FD_PC},    32'h10);

        // PC wrap at the top of the word address space.
        REDIRECT = 1'b1;
        REDIRECT_PC = 30'h3FFF_FFFF;
        tick();
        REDIRECT = 1'b0;
        chk("wr_iaddr", {2'b00, IADDR}, 32'h3FFF_FFFF);
        tick();
        chk("wr_wrap",  {2'b00, IADDR}, 32'd0);
        chk("wr_fdpc",  {2'b00, FD_PC}, 32'h3FFF_FFFF);
        chk("wr_link",  FD_LINK,        32'h0000_0000);

        // Reset pulsed during HOLD at PC=0x22.
        REDIRECT = 1'b1;
        REDIRECT_PC = 30'h22;
        tick();
        REDIRECT = 1'b0;
        STALL = 1'b1;
        tick();
        tick();
        chk("rh_hold_ireq", {31'd0, IREQ},  32'd0);
        chk("rh_hold_addr", {2'b00, IADDR}, 32'h22);
        #2 RSTN = 1'b0;
        #1;
        chk("rh_ireq",  {31'd0, IREQ},     32'd0);
        chk("rh_valid", {31'd0, FD_VALID}, 32'd0);
        chk("rh_iaddr", {2'b00, IADDR},    {2'b00, RST_PC});
        STALL = 1'b0;
        tick();
        #2 RSTN = 1'b1;
        tick();
        chk("rh_rel_ireq", {31'd0, IREQ},  32'd1);
        chk("rh_rel_addr", {2'b00, IADDR}, {2'b00, RST_PC});

        // Redirect arriving during the IDLE cycle right after reset.
        tick();
        #2 RSTN = 1'b0;
        tick();
        #2 RSTN = 1'b1;
        REDIRECT = 1'b1;
        REDIRECT_PC = 30'h77;
        tick();
        REDIRECT = 1'b0;
        chk("ri_iaddr", {2'b00, IADDR},    32'h77);
        chk("ri_ireq",  {31'd0, IREQ},     32'd1);
        chk("ri_valid", {31'd0, FD_VALID}, 32'd0);

        // Mixed stall/redirect pattern checked by the model alone.
        for (int i = 0; i < 40; i++) begin
            STALL = ((i % 7) == 2) || ((i % 7) == 3) || ((i % 13) == 9);
            REDIRECT = ((i % 11) == 5) || (i == 24);
            REDIRECT_PC = 30'h100 + 30'(i);
            tick();
        end
        STALL = 1'b0;
        REDIRECT = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
